// File: rtl/led_pwm_fader.sv
// Per-channel PWM LED driver: each channel's brightness ramps one step per
// prescaler tick toward its requested on/off state, then drives a PWM output.
module led_pwm_fader #(
    parameter int unsigned N_LEDS   = 8,
    parameter int unsigned PWM_BITS = 8,
    parameter int unsigned RAMP_DIV = 4096
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic [N_LEDS-1:0] led_in,
    output logic [N_LEDS-1:0] led_out,
    output logic              settled
);

    localparam int unsigned           PRE_BITS  = (RAMP_DIV > 2) ? $clog2(RAMP_DIV) : 1;
    localparam logic [PWM_BITS-1:0]   MAX_LEVEL = '1;
    localparam logic [PRE_BITS-1:0]   PRE_LAST  = PRE_BITS'(RAMP_DIV - 1);

    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PRE_BITS-1:0] prescaler;
    logic [N_LEDS-1:0]   led_in_q;
    logic [PWM_BITS-1:0] level [N_LEDS];
    logic                ramp_tick;
    logic [N_LEDS-1:0]   at_target;

    always_comb begin
        ramp_tick = (prescaler == PRE_LAST);
        at_target = '0;
        for (int unsigned i = 0; i < N_LEDS; i++) begin
            at_target[i] = (level[i] == (led_in_q[i] ? MAX_LEVEL : '0));
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            pwm_cnt   <= '0;
            prescaler <= '0;
            led_in_q  <= '0;
            led_out   <= '0;
            settled   <= 1'b0;
            for (int unsigned i = 0; i < N_LEDS; i++) begin
                level[i] <= '0;
            end
        end else begin
            pwm_cnt   <= pwm_cnt + PWM_BITS'(1);
            prescaler <= ramp_tick ? '0 : prescaler + PRE_BITS'(1);
            led_in_q  <= led_in;
            settled   <= &at_target;
            for (int unsigned i = 0; i < N_LEDS; i++) begin
                // Saturating step: held at the rails, never wraps.
                if (ramp_tick) begin
                    if (led_in_q[i] && level[i] != MAX_LEVEL) begin
                        level[i] <= level[i] + PWM_BITS'(1);
                    end else if (!led_in_q[i] && level[i] != '0) begin
                        level[i] <= level[i] - PWM_BITS'(1);
                    end
                end
                led_out[i] <= (level[i] == MAX_LEVEL) || (level[i] > pwm_cnt);
            end
        end
    end

endmodule

// File: tb/tb_led_pwm_fader.sv
// Self-checking bench for led_pwm_fader against a cycle-indexed behavioural model.
module tb_led_pwm_fader;

    localparam int NL    = 8;
    localparam int PB    = 4;
    localparam int RDIV  = 4;
    localparam int MAXL  = (1 << PB) - 1;
    localparam int PER   = 1 << PB;

    logic          sys_clk = 1'b0;
    logic          sys_rst = 1'b1;
    logic [NL-1:0] led_in  = '0;
    logic [NL-1:0] led_out;
    logic          settled;

    int total = 0;
    int bad   = 0;

    led_pwm_fader #(
        .N_LEDS  (NL),
        .PWM_BITS(PB),
        .RAMP_DIV(RDIV)
    ) dut (
        .sys_clk(sys_clk),
        .sys_rst(sys_rst),
        .led_in (led_in),
        .led_out(led_out),
        .settled(settled)
    );

    always #5 sys_clk = ~sys_clk;

    // Model: m_t counts cycles since reset release; PWM phase and tick
    // position follow from it arithmetically.
    bit          m_valid = 0;
    int unsigned m_t = 0;
    bit [NL-1:0] m_q = '0;
    bit [NL-1:0] m_out = '0;
    bit          m_settled = 0;
    int          m_level [NL];
    int          m_pwm;
    bit          m_tick;
    bit          m_all;

    always @(posedge sys_clk) begin
        if (sys_rst) begin
            m_valid = 1; m_t = 0; m_q = '0; m_out = '0; m_settled = 0;
            for (int i = 0; i < NL; i++) m_level[i] = 0;
        end else begin
            m_pwm  = int'(m_t % PER);
            m_tick = (m_t % RDIV) == RDIV - 1;
            m_all  = 1;
            for (int i = 0; i < NL; i++) begin
                m_out[i] = (m_level[i] == MAXL) || (m_level[i] > m_pwm);
                if (m_level[i] != (m_q[i] ? MAXL : 0)) m_all = 0;
            end
            m_settled = m_all;
            if (m_tick)
                for (int i = 0; i < NL; i++)
                    m_level[i] = m_q[i] ? ((m_level[i] < MAXL) ? m_level[i] + 1 : MAXL)
                                        : ((m_level[i] > 0) ? m_level[i] - 1 : 0);
            m_q = led_in;
            m_t++;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d t=%0d", name, act, exp, m_t);
        end
    endtask

    always @(negedge sys_clk) begin
        if (m_valid) begin
            check("led_out_vs_model", int'(led_out), int'(m_out));
            check("settled_vs_model", int'(settled), int'(m_settled));
        end
    end

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        sys_rst = 1'b1;
        repeat (n) step();
        sys_rst = 1'b0;
    endtask

    task automatic wait_t(input int unsigned n);
        int k = 0;
        while (m_t != n && k < 2000) begin
            step();
            k++;
        end
        if (m_t != n) check("wait_t_timeout", int'(m_t), int'(n));
    endtask

    task automatic count_high(input int idx, input int n, output int c);
        c = 0;
        repeat (n) begin
            @(negedge sys_clk);
            c += int'(led_out[idx]);
            step();
        end
    endtask

    int cnt;

    initial begin
        // Idle after reset
        step(); step();
        @(negedge sys_clk);
        check("settled_in_reset", int'(settled), 0);
        step();
        do_reset(1);
        led_in = 8'h00;
        @(negedge sys_clk);
        check("settled_at_release", int'(settled), 0);
        step();
        @(negedge sys_clk);
        check("settled_after_release", int'(settled), 1);
        wait_t(200);
        @(negedge sys_clk);
        check("idle_led_out", int'(led_out), 0);

        // Fade-up on channel 0; level 8..11 spans the window t=32..47
        do_reset(3);
        led_in = 8'h01;
        wait_t(33);
        count_high(0, 16, cnt);
        check("duty_window_ch0", cnt, 10);
        wait_t(70);
        @(negedge sys_clk);
        check("fullon_led_out", int'(led_out), 1);
        check("fullon_settled", int'(settled), 1);
        check("model_level0_full", m_level[0], 15);

        // Reversal on channel 3 at level 5
        do_reset(3);
        led_in = 8'h08;
        wait_t(20);
        check("model_ch3_lvl5", m_level[3], 5);
        led_in = 8'h00;
        wait_t(24);
        check("model_ch3_lvl4", m_level[3], 4);
        wait_t(40);
        check("model_ch3_lvl0", m_level[3], 0);
        step();
        count_high(3, 40, cnt);
        check("ch3_silent_after_reversal", cnt, 0);
        check("model_ch3_no_underflow", m_level[3], 0);

        // Short pulse on channel 2 landing in led_in_q only on prescaler 0..1
        do_reset(3);
        led_in = 8'h00;
        wait_t(7);
        led_in = 8'h04;
        step(); step();
        led_in = 8'h00;
        wait_t(20);
        check("model_ch2_pulse_ignored", m_level[2], 0);
        count_high(2, 16, cnt);
        check("ch2_silent_after_pulse", cnt, 0);

        // Reset mid-fade at level 9
        do_reset(3);
        led_in = 8'hFF;
        wait_t(37);
        check("model_all_lvl9", m_level[5], 9);
        sys_rst = 1'b1;
        step();
        @(negedge sys_clk);
        check("midfade_rst_led_out", int'(led_out), 0);
        check("midfade_rst_settled", int'(settled), 0);
        sys_rst = 1'b0;
        led_in  = 8'h00;
        step();
        cnt = 0;
        repeat (16) begin
            @(negedge sys_clk);
            if (led_out != 0) cnt++;
            step();
        end
        check("silent_after_midfade_rst", cnt, 0);

        // Simultaneous up on ch1 and down on ch0
        do_reset(3);
        led_in = 8'h01;
        wait_t(64);
        check("model_ch0_full_before_mix", m_level[0], 15);
        @(negedge sys_clk);
        check("mix_settled_before", int'(settled), 1);
        led_in = 8'h02;
        wait_t(66);
        @(negedge sys_clk);
        check("mix_settled_drop", int'(settled), 0);
        wait_t(68);
        check("model_mix_ch0_14", m_level[0], 14);
        check("model_mix_ch1_1", m_level[1], 1);
        wait_t(124);
        @(negedge sys_clk);
        check("mix_settled_t124", int'(settled), 0);
        wait_t(125);
        @(negedge sys_clk);
        check("mix_settled_t125", int'(settled), 1);

        // Random requests with occasional resets
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(7) == 0) led_in = NL'($urandom);
            sys_rst = ($urandom_range(499) == 0);
            step();
        end
        sys_rst = 1'b0;
        repeat (4) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
